// File: rtl/gpu_pipe_sequencer.sv
// gpu_pipe_sequencer
// ------------------
// Command sequencer and pipeline-advance controller for the GPU render
// pipeline. Host commands arrive on a valid/ready handshake. Each command is
// decoded into one-cycle reset/read/write strobes for one of NUM_PIPES memory
// pipes, and the sequencer then waits for that pipe's done flag. Read data is
// captured into dataOut. A single-cycle pipeline-advance enable replaces the
// old gated pipeline clock. Every wait is guarded by a timeout.
//
// Ports
//   gpuClock, reset          clock (rising edge) and synchronous active-high reset
//   cmdValid / cmdReady      command handshake
//   command[15:0]            [15:14] op, [13:11] target (pipe i = target i+1), [4:0] layer
//   data                     write data latched with the command
//   pipeDone                 per-pipe done flags
//   pipeX, pipeY             per-pipe pixel position, pipe i at [i*COORD_W +: COORD_W]
//   pipeRdData               per-pipe read data, pipe i at [i*DATA_W +: DATA_W]
//   pixelFound, paletteX/Y   palette stage: resolved non-transparent pixel and its position
//   pixelCntX/Y              pixel counter position
//   pipeRst, pipeRd, pipeWr  one-cycle strobes per pipe
//   pipelineData             latched command data
//   commandLayer             latched command layer
//   dataOut, dataOutValid    captured read data and its one-cycle valid pulse
//   pipeAdvance              one-cycle pipeline advance enable
//   pixelInc                 one-cycle pixel counter increment
//   timeoutErr               sticky timeout flag (cleared by reset only)
module gpu_pipe_sequencer #(
    parameter int NUM_PIPES = 2,
    parameter int DATA_W    = 16,
    parameter int COORD_W   = 11,
    parameter int TIMEOUT   = 255
) (
    input  logic                         gpuClock,
    input  logic                         reset,
    input  logic                         cmdValid,
    output logic                         cmdReady,
    input  logic [15:0]                  command,
    input  logic [DATA_W-1:0]            data,
    input  logic [NUM_PIPES-1:0]         pipeDone,
    input  logic [NUM_PIPES*COORD_W-1:0] pipeX,
    input  logic [NUM_PIPES*COORD_W-1:0] pipeY,
    input  logic [NUM_PIPES*DATA_W-1:0]  pipeRdData,
    input  logic                         pixelFound,
    input  logic [COORD_W-1:0]           paletteX,
    input  logic [COORD_W-1:0]           paletteY,
    input  logic [COORD_W-1:0]           pixelCntX,
    input  logic [COORD_W-1:0]           pixelCntY,
    output logic [NUM_PIPES-1:0]         pipeRst,
    output logic [NUM_PIPES-1:0]         pipeRd,
    output logic [NUM_PIPES-1:0]         pipeWr,
    output logic [DATA_W-1:0]            pipelineData,
    output logic [4:0]                   commandLayer,
    output logic [DATA_W-1:0]            dataOut,
    output logic                         dataOutValid,
    output logic                         pipeAdvance,
    output logic                         pixelInc,
    output logic                         timeoutErr
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    localparam logic [2:0] MAX_TARGET = 3'(NUM_PIPES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        WR_WAIT = 2'd3
    } seqState_t;

    seqState_t          stateReg;
    logic [1:0]         cmdOpReg;
    logic [2:0]         cmdTargetReg;
    logic [TO_W-1:0]    timeoutCntReg;

    // Per-pipe views padded out to the full 3-bit target space, so the
    // target index never selects outside an array. Pipes that do not exist
    // report "not done", zero data and "position matches" (the last keeps
    // the all-pipes AND reduction neutral).
    logic [7:0]         doneVec;
    logic [7:0]         xyMatch;
    logic [DATA_W-1:0]  rdDataArr [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_pipeView
        if (gi < NUM_PIPES) begin : g_real
            assign doneVec[gi]   = pipeDone[gi];
            assign rdDataArr[gi] = pipeRdData[gi*DATA_W +: DATA_W];
            assign xyMatch[gi]   = (pipeX[gi*COORD_W +: COORD_W] == paletteX) &&
                                   (pipeY[gi*COORD_W +: COORD_W] == paletteY);
        end else begin : g_pad
            assign doneVec[gi]   = 1'b0;
            assign rdDataArr[gi] = '0;
            assign xyMatch[gi]   = 1'b1;
        end
    end

    // Reserved command bits carry no meaning for this block.
    logic unusedCommandBits;
    assign unusedCommandBits = ^command[10:5];

    logic [2:0]           tgtIdx;
    logic                 tgtValid;
    logic [NUM_PIPES-1:0] tgtOneHot;
    logic                 tgtDone;
    logic                 advanceCond;
    logic                 incCond;
    logic                 timeoutHit;
    logic                 idleNoCmd;

    always_comb begin
        tgtIdx      = cmdTargetReg - 3'd1;
        tgtValid    = (cmdTargetReg != 3'd0) && (cmdTargetReg <= MAX_TARGET);
        tgtOneHot   = NUM_PIPES'(1) << tgtIdx;
        tgtDone     = doneVec[tgtIdx];
        // Either every pipe has finished, or the palette stage has already
        // resolved an opaque pixel at the position all pipes are working on.
        advanceCond = (&pipeDone) || (pixelFound && (&xyMatch));
        incCond     = pixelFound && (pixelCntX == paletteX) && (pixelCntY == paletteY);
        // The counter holds the number of completed wait cycles; the cycle
        // that would make it TIMEOUT is the one that gives up.
        timeoutHit  = (timeoutCntReg == TO_W'(TIMEOUT - 1));
        // In IDLE a present command is always accepted, and acceptance
        // takes priority over advancing the pipeline.
        idleNoCmd   = (stateReg == IDLE) && !cmdValid;
    end

    assign cmdReady = (stateReg == IDLE);

    always_ff @(posedge gpuClock) begin
        if (reset) begin
            stateReg      <= IDLE;
            cmdOpReg      <= 2'b00;
            cmdTargetReg  <= 3'd0;
            timeoutCntReg <= '0;
            pipeRst       <= '0;
            pipeRd        <= '0;
            pipeWr        <= '0;
            pipelineData  <= '0;
            commandLayer  <= '0;
            dataOut       <= '0;
            dataOutValid  <= 1'b0;
            pipeAdvance   <= 1'b0;
            pixelInc      <= 1'b0;
            timeoutErr    <= 1'b0;
        end else begin
            // Strobes and pulses are single-cycle unless re-asserted below.
            pipeRst      <= '0;
            pipeRd       <= '0;
            pipeWr       <= '0;
            dataOutValid <= 1'b0;

            // Self-holdoff: a pulse is always followed by at least one low
            // cycle, so a held condition produces 1,0,1,0...
            pipeAdvance <= idleNoCmd && advanceCond && !pipeAdvance;
            pixelInc    <= incCond && !pixelInc;

            case (stateReg)
                IDLE: begin
                    if (cmdValid) begin
                        cmdOpReg     <= command[15:14];
                        cmdTargetReg <= command[13:11];
                        commandLayer <= command[4:0];
                        pipelineData <= data;
                        stateReg     <= ISSUE;
                    end
                end

                ISSUE: begin
                    timeoutCntReg <= '0;
                    stateReg      <= IDLE;
                    case (cmdOpReg)
                        OP_RESET: begin
                            if (cmdTargetReg == 3'd0) begin
                                pipeRst <= '1;
                            end else if (tgtValid) begin
                                pipeRst <= tgtOneHot;
                            end
                        end
                        OP_READ: begin
                            if (tgtValid) begin
                                pipeRd   <= tgtOneHot;
                                stateReg <= RD_WAIT;
                            end
                        end
                        OP_WRITE: begin
                            if (tgtValid) begin
                                pipeWr   <= tgtOneHot;
                                stateReg <= WR_WAIT;
                            end
                        end
                        default: begin
                            // nop: nothing to issue
                        end
                    endcase
                end

                RD_WAIT, WR_WAIT: begin
                    // A done in the same cycle as the timeout still counts
                    // as a successful completion.
                    if (tgtDone) begin
                        if (stateReg == RD_WAIT) begin
                            dataOut      <= rdDataArr[tgtIdx];
                            dataOutValid <= 1'b1;
                        end
                        stateReg <= IDLE;
                    end else if (timeoutHit) begin
                        timeoutErr <= 1'b1;
                        stateReg   <= IDLE;
                    end else begin
                        timeoutCntReg <= timeoutCntReg + TO_W'(1);
                    end
                end

                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_pipe_sequencer.sv
// tb_gpu_pipe_sequencer
// ---------------------
// Self-checking bench for gpu_pipe_sequencer. Directed scenarios for the
// basic command flow, timeout, advance/holdoff and priority rules, followed
// by randomized commands and advance bursts checked against a transaction
// level model (expected strobes from op/target arithmetic, captured data,
// sticky error, advance/increment rules with holdoff).
module tb_gpu_pipe_sequencer;

    localparam int NP = 2;
    localparam int DW = 16;
    localparam int CW = 11;
    localparam int TO = 255;

    logic              gpuClock;
    logic              reset;
    logic              cmdValid;
    logic              cmdReady;
    logic [15:0]       command;
    logic [DW-1:0]     data;
    logic [NP-1:0]     pipeDone;
    logic [NP*CW-1:0]  pipeX;
    logic [NP*CW-1:0]  pipeY;
    logic [NP*DW-1:0]  pipeRdData;
    logic              pixelFound;
    logic [CW-1:0]     paletteX;
    logic [CW-1:0]     paletteY;
    logic [CW-1:0]     pixelCntX;
    logic [CW-1:0]     pixelCntY;
    logic [NP-1:0]     pipeRst;
    logic [NP-1:0]     pipeRd;
    logic [NP-1:0]     pipeWr;
    logic [DW-1:0]     pipelineData;
    logic [4:0]        commandLayer;
    logic [DW-1:0]     dataOut;
    logic              dataOutValid;
    logic              pipeAdvance;
    logic              pixelInc;
    logic              timeoutErr;

    gpu_pipe_sequencer #(
        .NUM_PIPES(NP),
        .DATA_W   (DW),
        .COORD_W  (CW),
        .TIMEOUT  (TO)
    ) dut (
        .gpuClock    (gpuClock),
        .reset       (reset),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .command     (command),
        .data        (data),
        .pipeDone    (pipeDone),
        .pipeX       (pipeX),
        .pipeY       (pipeY),
        .pipeRdData  (pipeRdData),
        .pixelFound  (pixelFound),
        .paletteX    (paletteX),
        .paletteY    (paletteY),
        .pixelCntX   (pixelCntX),
        .pixelCntY   (pixelCntY),
        .pipeRst     (pipeRst),
        .pipeRd      (pipeRd),
        .pipeWr      (pipeWr),
        .pipelineData(pipelineData),
        .commandLayer(commandLayer),
        .dataOut     (dataOut),
        .dataOutValid(dataOutValid),
        .pipeAdvance (pipeAdvance),
        .pixelInc    (pixelInc),
        .timeoutErr  (timeoutErr)
    );

    initial gpuClock = 1'b0;
    always #5 gpuClock = ~gpuClock;

    int checkCnt = 0;
    int passCnt  = 0;

    // Reference model state
    logic [DW-1:0] expDataOut;
    logic          expTimeoutErr;
    logic          expAdvPrev;
    logic          expIncPrev;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge gpuClock);
        #1;
    endtask

    task automatic setPipeXY(input int idx, input int x, input int y);
        pipeX[idx*CW +: CW] = CW'(x);
        pipeY[idx*CW +: CW] = CW'(y);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        checkVal("rst_cmdReady", cmdReady, 1);
        checkVal("rst_strobes", {pipeRst, pipeRd, pipeWr}, 0);
        checkVal("rst_dataOut", dataOut, 0);
        checkVal("rst_dataOutValid", dataOutValid, 0);
        checkVal("rst_pipelineData", pipelineData, 0);
        checkVal("rst_commandLayer", commandLayer, 0);
        checkVal("rst_pipeAdvance", pipeAdvance, 0);
        checkVal("rst_pixelInc", pixelInc, 0);
        checkVal("rst_timeoutErr", timeoutErr, 0);
        reset         = 1'b0;
        expDataOut    = '0;
        expTimeoutErr = 1'b0;
        expAdvPrev    = 1'b0;
        expIncPrev    = 1'b0;
    endtask

    // Handshake one command; issueDone is driven during the ISSUE cycle,
    // where it must have no effect. Returns after the ISSUE-exit edge.
    task automatic sendCmd(input logic [15:0] cmd, input logic [DW-1:0] wdata,
                           input logic [NP-1:0] issueDone);
        checkVal("cmdReady_idle", cmdReady, 1);
        cmdValid = 1'b1;
        command  = cmd;
        data     = wdata;
        tick();
        cmdValid = 1'b0;
        command  = 16'($urandom);
        data     = DW'($urandom);
        checkVal("cmdReady_issue", cmdReady, 0);
        checkVal("noStrobe_issue", {pipeRst, pipeRd, pipeWr}, 0);
        checkVal("noAdv_accept", pipeAdvance, 0);
        pipeDone = issueDone;
        tick();
        checkVal("noAdv_issue", pipeAdvance, 0);
        pipeDone = '0;
    endtask

    // One full command transaction against the model.
    task automatic runCmd(input logic [15:0] cmd, input logic [DW-1:0] wdata,
                          input int delay, input bit neverDone, input logic [DW-1:0] rdWord);
        logic [1:0]    op;
        logic [2:0]    tgt;
        bit            tv;
        bit            waits;
        logic [NP-1:0] bitMask;
        logic [NP-1:0] eRst;
        logic [NP-1:0] eRd;
        logic [NP-1:0] eWr;
        op      = cmd[15:14];
        tgt     = cmd[13:11];
        tv      = (int'(tgt) >= 1) && (int'(tgt) <= NP);
        bitMask = '0;
        if (tv) bitMask[int'(tgt) - 1] = 1'b1;
        eRst    = (op == 2'b00) ? ((tgt == 3'd0) ? {NP{1'b1}} : bitMask) : '0;
        eRd     = (op == 2'b01) ? bitMask : '0;
        eWr     = (op == 2'b10) ? bitMask : '0;
        waits   = tv && (op == 2'b01 || op == 2'b10);

        sendCmd(cmd, wdata, NP'($urandom));
        checkVal("strobe_rst", pipeRst, eRst);
        checkVal("strobe_rd", pipeRd, eRd);
        checkVal("strobe_wr", pipeWr, eWr);
        checkVal("latch_data", pipelineData, wdata);
        checkVal("latch_layer", commandLayer, cmd[4:0]);
        checkVal("cmdReady_after_issue", cmdReady, !waits);

        if (waits) begin
            if (neverDone) begin
                for (int k = 0; k < TO - 1; k++) begin
                    pipeDone = NP'($urandom) & ~bitMask;
                    tick();
                end
                checkVal("timeout_not_early", timeoutErr, expTimeoutErr);
                checkVal("busy_before_timeout", cmdReady, 0);
                pipeDone = NP'($urandom) & ~bitMask;
                tick();
                expTimeoutErr = 1'b1;
                checkVal("timeout_set", timeoutErr, 1);
                checkVal("timeout_idle", cmdReady, 1);
                checkVal("timeout_noValid", dataOutValid, 0);
                checkVal("timeout_dataHeld", dataOut, expDataOut);
            end else begin
                for (int k = 0; k < delay; k++) begin
                    pipeDone = NP'($urandom) & ~bitMask;
                    tick();
                    checkVal("wait_busy", cmdReady, 0);
                    checkVal("wait_noValid", dataOutValid, 0);
                end
                for (int i = 0; i < NP; i++) pipeRdData[i*DW +: DW] = DW'($urandom);
                pipeRdData[(int'(tgt) - 1)*DW +: DW] = rdWord;
                pipeDone = NP'($urandom) | bitMask;
                tick();
                if (op == 2'b01) expDataOut = rdWord;
                checkVal("done_valid", dataOutValid, (op == 2'b01));
                checkVal("done_data", dataOut, expDataOut);
                checkVal("done_idle", cmdReady, 1);
            end
        end

        pipeDone = '0;
        tick();
        checkVal("strobes_clear", {pipeRst, pipeRd, pipeWr}, 0);
        checkVal("valid_clear", dataOutValid, 0);
        checkVal("data_hold", dataOut, expDataOut);
        checkVal("timeoutErr", timeoutErr, expTimeoutErr);
        checkVal("ready_end", cmdReady, 1);
        expAdvPrev = 1'b0;
        expIncPrev = 1'b0;
    endtask

    // One idle cycle checked against the advance / pixel-increment rules.
    task automatic advStep(input string tag);
        bit   condA;
        bit   condB;
        bit   condInc;
        logic expA;
        logic expI;
        condA = (pipeDone == {NP{1'b1}});
        condB = pixelFound;
        for (int i = 0; i < NP; i++) begin
            if (pipeX[i*CW +: CW] != paletteX || pipeY[i*CW +: CW] != paletteY) condB = 0;
        end
        condInc = pixelFound && (pixelCntX == paletteX) && (pixelCntY == paletteY);
        expA = (condA || condB) && !cmdValid && !expAdvPrev;
        expI = condInc && !expIncPrev;
        tick();
        checkVal({tag, "_adv"}, pipeAdvance, expA);
        checkVal({tag, "_inc"}, pixelInc, expI);
        expAdvPrev = expA;
        expIncPrev = expI;
    endtask

    task automatic clearAdvInputs();
        pipeDone   = '0;
        pixelFound = 1'b0;
        pixelCntX  = '0;
        pixelCntY  = '0;
        paletteX   = 11'd1;
        paletteY   = 11'd1;
        for (int i = 0; i < NP; i++) setPipeXY(i, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        cmdValid   = 1'b0;
        command    = '0;
        data       = '0;
        pipeRdData = '0;
        pipeX      = '0;
        pipeY      = '0;
        clearAdvInputs();
        doReset();

        // Read target 2 returns 0xBEEF
        runCmd(16'h5000, 16'h0000, 0, 1'b0, 16'hBEEF);
        checkVal("t1_dataOut", dataOut, 16'hBEEF);

        // Reset all pipes, then an out-of-range target
        runCmd(16'h0000, 16'h0000, 0, 1'b0, 16'h0000);
        runCmd(16'h3000, 16'h0000, 0, 1'b0, 16'h0000);

        // Write that never completes: timeout, sticky error
        runCmd(16'h8805, 16'h1234, 0, 1'b1, 16'h0000);
        for (int k = 0; k < 3; k++) advStep("t3_idle");
        checkVal("t3_sticky", timeoutErr, 1);

        // All pipes done held for 4 idle cycles -> 1,0,1,0
        pipeDone = 2'b11;
        for (int k = 0; k < 4; k++) begin
            advStep("t4");
            checkVal("t4_pattern", pipeAdvance, (k % 2 == 0));
        end
        pipeDone = '0;
        advStep("t4_end");

        // Early skip: pixel already resolved at every pipe's position
        pixelFound = 1'b1;
        paletteX   = 11'd10;
        paletteY   = 11'd20;
        for (int i = 0; i < NP; i++) setPipeXY(i, 10, 20);
        advStep("t5_match");
        checkVal("t5_adv", pipeAdvance, 1);
        setPipeXY(0, 11, 20);
        advStep("t5_holdoff");
        advStep("t5_mismatch");
        checkVal("t5_noAdv", pipeAdvance, 0);

        // Pixel increment with holdoff
        paletteX  = 11'd5;
        paletteY  = 11'd5;
        pixelCntX = 11'd5;
        pixelCntY = 11'd5;
        advStep("t6_a");
        checkVal("t6_inc", pixelInc, 1);
        advStep("t6_b");
        checkVal("t6_holdoff", pixelInc, 0);
        advStep("t6_c");
        clearAdvInputs();
        advStep("t6_end1");
        advStep("t6_end2");

        // Command accepted together with all-done: command wins
        pipeDone = 2'b11;
        sendCmd(16'hC000, 16'h0000, 2'b11);
        checkVal("t7_noStrobe", {pipeRst, pipeRd, pipeWr}, 0);
        checkVal("t7_idle", cmdReady, 1);
        expAdvPrev = 1'b0;
        expIncPrev = 1'b0;
        advStep("t7_after");

        // Reset while waiting for a read: no capture follows
        sendCmd(16'h4800, 16'h0000, 2'b00);
        pipeRdData = {16'h1111, 16'h2222};
        pipeDone   = 2'b01;
        reset      = 1'b1;
        tick();
        reset      = 1'b0;
        pipeDone   = '0;
        checkVal("rstWait_valid", dataOutValid, 0);
        checkVal("rstWait_data", dataOut, 0);
        checkVal("rstWait_ready", cmdReady, 1);
        tick();
        checkVal("rstWait_valid2", dataOutValid, 0);
        checkVal("rstWait_strobes", {pipeRst, pipeRd, pipeWr}, 0);

        // Reset during ISSUE: strobe never appears
        cmdValid = 1'b1;
        command  = 16'h4800;
        tick();
        cmdValid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        checkVal("rstIssue_strobes", {pipeRst, pipeRd, pipeWr}, 0);
        tick();
        checkVal("rstIssue_strobes2", {pipeRst, pipeRd, pipeWr}, 0);
        checkVal("rstIssue_ready", cmdReady, 1);
        doReset();

        // Randomized commands and advance bursts
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                logic [15:0] cmd;
                bit          nd;
                cmd = {2'($urandom), 3'($urandom), 6'($urandom), 5'($urandom)};
                nd  = ($urandom_range(9, 0) == 0);
                runCmd(cmd, DW'($urandom), $urandom_range(5, 0), nd, DW'($urandom));
            end else begin
                for (int s = 0; s < 8; s++) begin
                    pipeDone   = ($urandom_range(1, 0) == 1) ? {NP{1'b1}} : NP'($urandom);
                    pixelFound = 1'($urandom);
                    paletteX   = CW'($urandom_range(4, 3));
                    paletteY   = CW'($urandom_range(4, 3));
                    pixelCntX  = CW'($urandom_range(4, 3));
                    pixelCntY  = CW'($urandom_range(4, 3));
                    for (int i = 0; i < NP; i++) begin
                        if ($urandom_range(3, 0) != 0) setPipeXY(i, int'(paletteX), int'(paletteY));
                        else setPipeXY(i, $urandom_range(4, 3), $urandom_range(4, 3));
                    end
                    advStep("rnd");
                end
                clearAdvInputs();
                advStep("rnd_end");
            end
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/gpu_pipe_sequencer.md
# gpu_pipe_sequencer

Parametrised command sequencer and pipeline-advance controller for the GPU render pipeline. It accepts host commands through a valid/ready handshake and decodes them into one-cycle read/write/reset strobes for NUM_PIPES memory pipes (RAM, flash, …). It captures read data and generates a single-cycle pipeline-advance enable, replacing the gated pipeline clock. The advance enable includes early-skip when a non-transparent pixel is already resolved, and a timeout guards every memory operation.

## Interface

- NUM_PIPES, 2: number of memory pipes (1–7); pipe i is command target i+1
- DATA_W, 16: data bus width
- COORD_W, 11: pixel coordinate width
- TIMEOUT, 255: max wait cycles for a pipe operation (≥1)

- gpuClock  in  1  GPU clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmdValid  in  1  command present
- cmdReady  out  1  sequencer can accept a command
- command  in  16  [15:14] op (00 reset, 01 read, 10 write, 11 nop), [13:11] target, [4:0] layer
- data  in  DATA_W  write data accompanying command
- pipeDone  in  NUM_PIPES  per-pipe operation/pixel done
- pipeX, pipeY  in  NUM_PIPES*COORD_W  per-pipe pixel position; pipe i at [i*COORD_W +: COORD_W]
- pipeRdData  in  NUM_PIPES*DATA_W  per-pipe read data
- pixelFound  in  1  palette stage found non-transparent pixel
- paletteX, paletteY  in  COORD_W  palette stage pixel position
- pixelCntX, pixelCntY  in  COORD_W  pixel counter position
- pipeRst, pipeRd, pipeWr  out  NUM_PIPES  one-cycle strobes per pipe
- pipelineData  out  DATA_W  latched command data
- commandLayer  out  5  latched command layer
- dataOut  out  DATA_W  captured read data
- dataOutValid  out  1  one-cycle pulse, dataOut valid
- pipeAdvance  out  1  one-cycle pipeline advance enable
- pixelInc  out  1  one-cycle pixel increment
- timeoutErr  out  1  sticky timeout flag

## Operation

- FSM states: IDLE, ISSUE, RD_WAIT, WR_WAIT.
- IDLE: cmdReady=1. On cmdValid, latch command, data, layer and go to ISSUE.
- ISSUE: cmdReady=0. Decode the latched op and target:
  - reset, target 0: pulse all pipeRst bits; go to IDLE.
  - reset, target t in 1..NUM_PIPES: pulse pipeRst[t-1]; go to IDLE.
  - read, valid t: pulse pipeRd[t-1]; go to RD_WAIT.
  - write, valid t: pulse pipeWr[t-1]; go to WR_WAIT.
  - nop, target 0 with read/write, or target > NUM_PIPES: no strobe; go to IDLE.
- RD_WAIT: when pipeDone[t-1]=1, register that pipe's pipeRdData into dataOut, pulse dataOutValid, and go to IDLE.
- WR_WAIT: when pipeDone[t-1]=1, go to IDLE.
- Timeout counter:
  - Cleared on entry to a WAIT state; increments each WAIT cycle.
  - When it reaches TIMEOUT with no done: set timeoutErr, go to IDLE, no dataOutValid; dataOut holds its old value.
  - timeoutErr clears only on reset.
- Advance (evaluated only while the FSM is in IDLE and no cmdValid is accepted that cycle):
  - Condition A: all pipeDone bits are 1.
  - Condition B: pixelFound=1 and every pipe's X/Y equals paletteX/paletteY.
  - pipeAdvance is registered and asserts for one cycle when A or B holds.
  - Holdoff: pipeAdvance never asserts on two consecutive cycles.
- pixelInc:
  - Registered; asserts when pixelFound=1 and pixelCnt X/Y equals palette X/Y.
  - Same one-cycle holdoff rule; independent of FSM state.

## Timing

- Reset values:
  - FSM=IDLE, cmdReady=1.
  - All strobes 0.
  - dataOut=0, dataOutValid=0.
  - pipelineData=0, commandLayer=0.
  - pipeAdvance=0, pixelInc=0, timeoutErr=0.
  - Timeout counter 0.
- Reset mid-operation aborts immediately; no strobe or dataOutValid follows.
- Command latency:
  - Accept at edge N; strobe high in cycle N+1.
  - Read done sampled at edge M → dataOut/dataOutValid valid in cycle M+1.
  - cmdReady returns 1 the cycle after leaving ISSUE or WAIT.
- Done arriving in the ISSUE cycle is ignored; it is only sampled in WAIT.
- Back-to-back commands: one command per at least 2 cycles (IDLE→ISSUE→IDLE).
- Advance latency: 1 cycle from the condition to pipeAdvance. A suppresses nothing; A and B together give one pulse.
- Accepting a command in the same cycle as an advance condition: command wins, no advance.
- Timeout fires exactly TIMEOUT cycles after WAIT entry.

## Test plan

- After reset: cmdReady=1 and all outputs 0. Send command 0x5000 (read, target 2) with NUM_PIPES=2 → pipeRd=2'b10 one cycle later. Raise pipeDone[1] with pipeRdData pipe1=0xBEEF → dataOut=0xBEEF and dataOutValid=1 for one cycle.
- Send 0x0000 (reset all) → pipeRst=2'b11 for one cycle, then IDLE. Send 0x3000 (target 6 > NUM_PIPES) → no strobe, cmdReady back to 1 after 2 cycles.
- Send write 0x8805 with data 0x1234 and never raise done → timeoutErr=1 after TIMEOUT=255 cycles in WAIT. Sequencer returns to IDLE; timeoutErr stays set until reset.
- Idle with pipeDone=2'b11 held for 4 cycles → pipeAdvance pattern 1,0,1,0.
- pipeDone=0, pixelFound=1, all pipe and palette XY=(10,20) → pipeAdvance pulses. Change pipe0 X to 11 → no advance.
- pixelFound=1 and pixelCnt=(5,5)=palette → pixelInc=1 next cycle. Assert cmdValid in the same cycle as pipeDone=2'b11 → no pipeAdvance.
